// File: rtl/idle_detect_multi.sv
// rtl/idle_detect_multi.sv - multi-lane idle detector with hysteresis and link FSM
module idle_detect_multi #(
    parameter int                LANES     = 4,
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  IDLE_SYM  = WIDTH'(8'h7C),
    parameter int                ENTER_CNT = 4,
    parameter int                EXIT_CNT  = 2
) (
    input  logic                   clk_4f,
    input  logic                   reset,
    input  logic                   active,
    input  logic [LANES-1:0]       valid_in,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic [LANES-1:0]       idle_out,
    output logic                   all_idle,
    output logic                   link_up,
    output logic [LANES-1:0]       lane_err
);

    localparam int MAX_CNT = (ENTER_CNT > EXIT_CNT) ? ENTER_CNT : EXIT_CNT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] ENTER_LAST = CW'(ENTER_CNT - 1);
    localparam logic [CW-1:0] EXIT_LAST  = CW'(EXIT_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        LINK_DOWN  = 2'd0,
        LINK_TRAIN = 2'd1,
        LINK_UP    = 2'd2
    } link_state_t;

    link_state_t state, state_nxt;

    logic [LANES-1:0] lane_act;
    logic [LANES-1:0] lane_act_nxt;
    logic [LANES-1:0] is_idle_sym;
    logic [LANES-1:0] data_qual;
    logic [LANES-1:0] idle_qual;
    logic [LANES-1:0] natural_drop;
    logic [CW-1:0]    cnt     [LANES];
    logic [CW-1:0]    cnt_nxt [LANES];
    logic             any_act_nxt;
    logic             all_act_nxt;

    for (genvar g = 0; g < LANES; g++) begin : g_lane_class
        assign is_idle_sym[g] = (data_in[g*WIDTH +: WIDTH] == IDLE_SYM);
    end

    assign data_qual = {LANES{active}} & valid_in & ~is_idle_sym;
    assign idle_qual = ~valid_in | is_idle_sym;

    // Per-lane hysteresis: one shared counter counts toward whichever transition applies.
    always_comb begin
        lane_act_nxt = lane_act;
        natural_drop = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt_nxt[i] = cnt[i];
            if (lane_act[i]) begin
                if (!active) begin
                    lane_act_nxt[i] = 1'b0;
                    cnt_nxt[i]      = '0;
                end else if (idle_qual[i]) begin
                    if (cnt[i] == ENTER_LAST) begin
                        lane_act_nxt[i] = 1'b0;
                        cnt_nxt[i]      = '0;
                        natural_drop[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end else begin
                    cnt_nxt[i] = '0;
                end
            end else begin
                if (data_qual[i]) begin
                    if (cnt[i] == EXIT_LAST) begin
                        lane_act_nxt[i] = 1'b1;
                        cnt_nxt[i]      = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end else begin
                    cnt_nxt[i] = '0;
                end
            end
        end
    end

    assign any_act_nxt = |lane_act_nxt;
    assign all_act_nxt = &lane_act_nxt;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state <= LINK_DOWN;
        end else begin
            state <= state_nxt;
        end
    end

    // Link decisions look at the lane next-state so link_up tracks the last lane without lag.
    always_comb begin
        state_nxt = state;
        case (state)
            LINK_DOWN: begin
                if (all_act_nxt) begin
                    state_nxt = LINK_UP;
                end else if (any_act_nxt) begin
                    state_nxt = LINK_TRAIN;
                end
            end
            LINK_TRAIN: begin
                if (all_act_nxt) begin
                    state_nxt = LINK_UP;
                end else if (!any_act_nxt) begin
                    state_nxt = LINK_DOWN;
                end
            end
            LINK_UP: begin
                if (!active || !any_act_nxt) begin
                    state_nxt = LINK_DOWN;
                end else if (!all_act_nxt) begin
                    state_nxt = LINK_TRAIN;
                end
            end
            default: state_nxt = LINK_DOWN;
        endcase
    end

    always_comb begin
        link_up = (state == LINK_UP);
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            lane_act <= '0;
            all_idle <= 1'b1;
            lane_err <= '0;
            for (int i = 0; i < LANES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            lane_act <= lane_act_nxt;
            all_idle <= ~any_act_nxt;
            if (state == LINK_UP) begin
                lane_err <= lane_err | natural_drop;
            end
            for (int i = 0; i < LANES; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign idle_out = ~lane_act;

endmodule

// File: tb/tb_idle_detect_multi.sv
// tb/tb_idle_detect_multi.sv - self-checking bench for idle_detect_multi
module tb_idle_detect_multi;

    localparam int         LANES = 4;
    localparam int         WIDTH = 8;
    localparam int         ENTER = 4;
    localparam int         EXIT  = 2;
    localparam logic [7:0] ISYM  = 8'h7C;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic        active;
    logic [3:0]  valid_in;
    logic [31:0] data_in;
    logic [3:0]  idle_out;
    logic        all_idle;
    logic        link_up;
    logic [3:0]  lane_err;

    int checks = 0;
    int errors = 0;

    // Reference: per-lane state plus length of the current qualifying run.
    bit         m_act [LANES];
    int         m_run [LANES];
    logic [3:0] m_err;
    bit         m_up;

    logic [31:0] rd;
    logic [3:0]  rv;
    logic        ra;
    logic        rr;
    int          idle_pct;

    idle_detect_multi #(
        .LANES(LANES), .WIDTH(WIDTH), .IDLE_SYM(ISYM),
        .ENTER_CNT(ENTER), .EXIT_CNT(EXIT)
    ) dut (
        .clk_4f(clk_4f), .reset(reset), .active(active), .valid_in(valid_in),
        .data_in(data_in), .idle_out(idle_out), .all_idle(all_idle),
        .link_up(link_up), .lane_err(lane_err)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int n;
        logic [3:0] drop;
        logic [7:0] sym;
        bit dq, iq;
        drop = '0;
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                m_act[i] = 0;
                m_run[i] = 0;
            end
            m_err = '0;
            m_up  = 0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                sym = data_in[i*8 +: 8];
                dq  = active && valid_in[i] && (sym != ISYM);
                iq  = !valid_in[i] || (sym == ISYM);
                if (m_act[i]) begin
                    if (!active) begin
                        m_act[i] = 0;
                        m_run[i] = 0;
                    end else if (iq) begin
                        m_run[i]++;
                        if (m_run[i] >= ENTER) begin
                            m_act[i] = 0;
                            m_run[i] = 0;
                            drop[i]  = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end else if (dq) begin
                    m_run[i]++;
                    if (m_run[i] >= EXIT) begin
                        m_act[i] = 1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (m_up) m_err = m_err | drop;
            n = 0;
            for (int i = 0; i < LANES; i++) n += m_act[i] ? 1 : 0;
            m_up = (n == LANES);
        end
    endtask

    task automatic compare_all(input string ctx);
        logic [3:0] exp_idle;
        for (int i = 0; i < LANES; i++) exp_idle[i] = !m_act[i];
        check({ctx, " idle_out"}, 32'(idle_out), 32'(exp_idle));
        check({ctx, " all_idle"}, 32'(all_idle), 32'(exp_idle == 4'hF));
        check({ctx, " link_up"},  32'(link_up),  32'(m_up));
        check({ctx, " lane_err"}, 32'(lane_err), 32'(m_err));
    endtask

    task automatic step(input logic a, input logic [3:0] v, input logic [31:0] d,
                        input logic r, input string ctx);
        reset    = r;
        active   = a;
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        model_edge();
        #1;
        compare_all(ctx);
    endtask

    initial begin
        reset    = 1'b1;
        active   = 1'b0;
        valid_in = '0;
        data_in  = '0;
        m_err    = '0;
        m_up     = 0;
        for (int i = 0; i < LANES; i++) begin
            m_act[i] = 0;
            m_run[i] = 0;
        end

        step(0, 4'h0, 32'h0, 1, "reset");
        step(0, 4'h0, 32'h0, 1, "reset");
        check("rst_idle_out", 32'(idle_out), 32'hF);
        check("rst_all_idle", 32'(all_idle), 32'h1);
        check("rst_link_up",  32'(link_up),  32'h0);
        check("rst_lane_err", 32'(lane_err), 32'h0);

        for (int k = 0; k < 10; k++) begin
            step(0, 4'($urandom), $urandom, 0, "inactive");
            check("inactive_idle_out", 32'(idle_out), 32'hF);
        end

        step(1, 4'hF, 32'hA5A5A5A5, 0, "exit1");
        check("exit_edge1_idle", 32'(idle_out), 32'hF);
        step(1, 4'hF, 32'hA5A5A5A5, 0, "exit2");
        check("exit_edge2_idle", 32'(idle_out), 32'h0);
        check("exit_edge2_link", 32'(link_up),  32'h1);

        repeat (3) step(1, 4'hF, 32'hA57CA5A5, 0, "hyst3");
        step(1, 4'hF, 32'hA5A5A5A5, 0, "hyst_clear");
        check("hyst_no_drop", 32'(idle_out), 32'h0);
        check("hyst_link",    32'(link_up),  32'h1);
        repeat (3) step(1, 4'hF, 32'hA57CA5A5, 0, "enter");
        check("enter3_idle", 32'(idle_out), 32'h0);
        step(1, 4'hF, 32'hA57CA5A5, 0, "enter4");
        check("enter4_idle", 32'(idle_out), 32'h4);
        check("enter4_link", 32'(link_up),  32'h0);
        check("enter4_err",  32'(lane_err), 32'h4);

        repeat (2) step(1, 4'hF, 32'hA5A5A5A5, 0, "relink");
        check("relink_up", 32'(link_up), 32'h1);
        step(0, 4'hF, 32'hA5A5A5A5, 0, "force");
        check("force_idle", 32'(idle_out), 32'hF);
        check("force_all",  32'(all_idle), 32'h1);
        check("force_link", 32'(link_up),  32'h0);
        check("force_err",  32'(lane_err), 32'h4);

        for (int k = 0; k < 4; k++) step(1, 4'((k % 2 == 0) ? 1 : 0), 32'h11111111, 0, "gap");
        check("gap_idle", 32'(idle_out), 32'hF);

        step(0, 4'h0, 32'h0, 1, "rst2");
        repeat (2) step(1, 4'hF, 32'hA5A5A5A5, 0, "up2");
        repeat (4) step(1, 4'hF, 32'hA5A5A57C, 0, "drop0");
        repeat (2) step(1, 4'hF, 32'hA5A5A5A5, 0, "up3");
        check("pre_rst_link", 32'(link_up),  32'h1);
        check("pre_rst_err",  32'(lane_err), 32'h1);
        step(1, 4'hF, 32'hA5A5A5A5, 1, "midrst");
        check("midrst_idle", 32'(idle_out), 32'hF);
        check("midrst_all",  32'(all_idle), 32'h1);
        check("midrst_link", 32'(link_up),  32'h0);
        check("midrst_err",  32'(lane_err), 32'h0);
        step(1, 4'hF, 32'hA5A5A5A5, 0, "restart1");
        check("restart1_idle", 32'(idle_out), 32'hF);
        step(1, 4'hF, 32'hA5A5A5A5, 0, "restart2");
        check("restart2_idle", 32'(idle_out), 32'h0);
        check("restart2_link", 32'(link_up),  32'h1);

        for (int k = 0; k < 600; k++) begin
            if (k % 60 == 0) idle_pct = $urandom_range(5, 60);
            rr = ($urandom_range(0, 149) == 0);
            ra = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < LANES; i++) begin
                rv[i] = ($urandom_range(0, 99) >= idle_pct / 2);
                rd[i*8 +: 8] = ($urandom_range(0, 99) < idle_pct) ? ISYM : 8'($urandom);
            end
            step(ra, rv, rd, rr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idle_detect_multi.md
Name: idle_detect_multi

Overview:
- Parametrised multi-lane successor to the single-lane IDL block, clocked from the clk_4f domain.
- Per lane, it tracks active/idle state from the received symbol stream, using separate consecutive-count thresholds for entering and leaving idle (hysteresis).
- It aggregates the lane states into a link-level FSM, which drives all_idle and link_up to the downstream serial/parallel stages.

Parameters:
- LANES, 4, number of independent lanes (1..8).
- WIDTH, 8, symbol width per lane in bits.
- IDLE_SYM, 8'h7C, symbol value treated as idle filler (low WIDTH bits used).
- ENTER_CNT, 4, consecutive idle-qualifying cycles needed to move a lane ACTIVE->IDLE (>=1).
- EXIT_CNT, 2, consecutive data-qualifying cycles needed to move a lane IDLE->ACTIVE (>=1).

Ports:
- clk_4f  input  1  block clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- active  input  1  global enable; 0 forces every lane to idle.
- valid_in  input  LANES  per-lane symbol-valid qualifier.
- data_in  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- idle_out  output  LANES  1 = lane i in IDLE state (registered).
- all_idle  output  1  1 = every lane idle (registered).
- link_up  output  1  1 = link FSM in UP (registered).
- lane_err  output  LANES  sticky; set when lane i drops ACTIVE->IDLE while link FSM is UP; cleared only by reset.

Behaviour:
- Reset: when reset=1 at a clk_4f edge:
  - all lane FSMs go to IDLE and all counters go to 0;
  - idle_out = all 1s, all_idle = 1, link_up = 0, lane_err = 0;
  - the link FSM goes to DOWN.
  - Reset asserted mid-operation has the same effect on the next edge.
- Symbol classification per lane, per cycle:
  - data-qualifying = active & valid_in[i] & (data_in lane != IDLE_SYM).
  - idle-qualifying = !valid_in[i] | (data_in lane == IDLE_SYM).
- Lane FSM, states IDLE and ACTIVE. Each lane has one counter, width $clog2(max(ENTER_CNT,EXIT_CNT)+1).
- IDLE state:
  - A data-qualifying cycle increments cnt. A non-qualifying cycle clears cnt to 0.
  - When a data-qualifying cycle finds cnt == EXIT_CNT-1: go to ACTIVE and clear cnt.
  - idle_out[i] falls on the same edge as the transition. Latency = EXIT_CNT edges from the first data symbol.
- ACTIVE state:
  - active=0 forces IDLE on the next edge regardless of cnt, and clears cnt.
  - Otherwise an idle-qualifying cycle increments cnt, and a data-qualifying cycle clears it.
  - When an idle-qualifying cycle finds cnt == ENTER_CNT-1: go to IDLE and clear cnt.
- Counters never wrap; the transition occurs before the maximum value is reached.
- Link FSM, states DOWN, TRAIN, UP:
  - DOWN -> TRAIN when any lane is ACTIVE (next-state view).
  - TRAIN -> UP when all lanes are ACTIVE.
  - TRAIN -> DOWN when all lanes are IDLE.
  - UP -> TRAIN when any lane, but not all lanes, goes IDLE.
  - UP -> DOWN when all lanes go IDLE on the same edge, or when active=0.
- Output timing:
  - link_up = (state == UP), registered; it asserts on the same edge the last lane enters ACTIVE.
  - all_idle = &idle_out, registered alongside idle_out (no extra cycle).
- lane_err[i] sets on the edge where lane i leaves ACTIVE while the link FSM is currently UP. A forced drop caused by active=0 does not set it.
- Simultaneous events: reset has priority over everything; active=0 has priority over counters.
- Degenerate thresholds: EXIT_CNT=1 / ENTER_CNT=1 mean a single qualifying cycle causes the transition.

Test Plan:
- Reset, then active=0 with 10 cycles of random data -> idle_out=4'b1111, all_idle=1, link_up=0, lane_err=0 throughout.
- active=1, valid_in=4'hF, all lanes data 8'hA5 -> idle_out goes 4'b0000 exactly 2 edges after the first symbol; link_up=1 on that same edge.
- While UP, lane 2 sends 8'h7C for 3 cycles, then 8'hA5 -> no transition, counter clears, link_up stays 1. Lane 2 then sends 4 cycles of 8'h7C -> idle_out=4'b0100, link_up=0 (state TRAIN), lane_err=4'b0100.
- While UP, drop active to 0 -> next edge idle_out=4'hF, all_idle=1, link_up=0, lane_err unchanged.
- Lane 0 valid_in toggles 1,0,1,0 with data 8'h11 -> lane 0 never leaves IDLE (counter clears on every gap).
- Assert reset for one cycle while UP with lane_err=4'b0001 -> next edge all outputs at reset values. Traffic then restarts and the lanes re-enter ACTIVE after 2 edges.
